// File: rtl/fifo_drain_arbiter.sv
// Round-robin read-side scheduler draining up to BURST_MAX words per grant from
// NUM_CH show-ahead FIFOs into one registered valid/ready output stage.
module fifo_drain_arbiter #(
  parameter  int NUM_CH     = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_MAX  = 4,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enable,
  input  logic [NUM_CH-1:0]            ch_empty,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_rd_data,
  output logic [NUM_CH-1:0]            ch_rd_en,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         busy,
  output logic [CH_W-1:0]              grant_ch
);

  localparam int BEAT_W = $clog2(BURST_MAX + 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e                  state_q;
  logic [CH_W-1:0]         grant_q;
  logic [BEAT_W-1:0]       beat_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [CH_W-1:0]         out_ch_q;
  logic                    out_valid_q;

  logic [NUM_CH-1:0]       req;
  logic                    sel_found;
  logic [CH_W-1:0]         sel_ch;
  logic                    grant_empty;
  logic [DATA_WIDTH-1:0]   grant_data;
  logic                    pop;
  logic                    last_beat;

  assign req = ~ch_empty;

  // Circular search starting one past the last grant, so a channel that just
  // finished a burst is considered last.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_found = 1'b0;
    sel_ch    = grant_q;
    for (int k = 1; k <= NUM_CH; k++) begin
      if (!sel_found && req[(int'(grant_q) + k) % NUM_CH]) begin
        sel_found = 1'b1;
        sel_ch    = CH_W'((int'(grant_q) + k) % NUM_CH);
      end
    end
  end

  always_comb begin
    grant_empty = 1'b1;
    grant_data  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == grant_q) begin
        grant_empty = ch_empty[i];
        grant_data  = ch_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A word may be popped whenever the output register is empty or being emptied.
  assign pop       = (state_q == S_BURST) && !grant_empty && (!out_valid_q || out_ready);
  assign last_beat = (beat_q == BEAT_W'(BURST_MAX - 1));

  always_comb begin
    ch_rd_en = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == grant_q) ch_rd_en[i] = pop;
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      grant_q     <= CH_W'(NUM_CH - 1);
      beat_q      <= '0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (pop) begin
        out_data_q  <= grant_data;
        out_ch_q    <= grant_q;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (enable && sel_found) begin
            grant_q <= sel_ch;
            beat_q  <= '0;
            state_q <= S_BURST;
          end
        end
        S_BURST: begin
          if (pop) beat_q <= beat_q + BEAT_W'(1);
          // Ends on the final beat, or as soon as the granted FIFO runs dry
          // (including before any beat, which still advances the pointer).
          if ((pop && last_beat) || grant_empty) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == S_BURST);
  assign grant_ch  = grant_q;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed bench for fifo_drain_arbiter: FIFO models feed the DUT, a scoreboard
// of hand-ordered expected words is checked by an independent output monitor.
module tb_fifo_drain_arbiter;

  localparam int NUM_CH    = 4;
  localparam int DW        = 8;
  localparam int BURST_MAX = 4;
  localparam int CH_W      = 2;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b1;
  logic                   enable = 1'b0;
  logic                   out_ready = 1'b1;
  logic [NUM_CH-1:0]      ch_empty = '1;
  logic [NUM_CH*DW-1:0]   ch_rd_data = '0;
  logic [NUM_CH-1:0]      ch_rd_en;
  logic [DW-1:0]          out_data;
  logic [CH_W-1:0]        out_ch;
  logic                   out_valid;
  logic                   busy;
  logic [CH_W-1:0]        grant_ch;

  fifo_drain_arbiter #(
    .NUM_CH    (NUM_CH),
    .DATA_WIDTH(DW),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ch_empty  (ch_empty),
    .ch_rd_data(ch_rd_data),
    .ch_rd_en  (ch_rd_en),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .grant_ch  (grant_ch)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // FIFO model: words written by stimulus, read pointer owned by the pop process.
  int wr_log [NUM_CH][$];
  int rd_ptr [NUM_CH] = '{default: 0};
  int pop_log [$];

  always @(posedge clk) begin
    if (ch_rd_en != '0) begin
      check("rd_en_onehot", int'($onehot(ch_rd_en)), 1);
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_rd_en[i]) begin
          check("pop_nonempty", int'(rd_ptr[i] < wr_log[i].size()), 1);
          if (rd_ptr[i] < wr_log[i].size()) rd_ptr[i] <= rd_ptr[i] + 1;
          pop_log.push_back(i);
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_empty[i] = (rd_ptr[i] >= wr_log[i].size());
      ch_rd_data[i*DW +: DW] = ch_empty[i] ? '0 : DW'(wr_log[i][rd_ptr[i]]);
    end
  end

  // Grant logger: one entry per rising edge of busy.
  int   gl_ch [$];
  int   gl_start [$];
  logic busy_prev = 1'b0;

  always begin
    @(negedge clk);
    #1;
    if (!rst_n) busy_prev = 1'b0;
    else begin
      if (busy && !busy_prev) begin
        gl_ch.push_back(int'(grant_ch));
        gl_start.push_back(pop_log.size());
      end
      busy_prev = busy;
    end
  end

  // Scoreboard monitor: a transfer happens on the coming edge when valid && ready.
  int exp_log [$];
  int mon_idx = 0;

  always begin
    @(negedge clk);
    #3;
    if (rst_n && out_valid && out_ready) begin
      if (mon_idx < exp_log.size())
        check("out_word", int'(out_ch) * 256 + int'(out_data), exp_log[mon_idx]);
      else
        check("unexpected_out", mon_idx, exp_log.size());
      mon_idx++;
    end
  end

  task automatic push(input int ch, input int d);
    wr_log[ch].push_back(d);
  endtask

  task automatic expect_word(input int ch, input int d);
    exp_log.push_back(ch * 256 + d);
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      #2;
      done = (mon_idx == exp_log.size()) && !busy && !out_valid && (ch_empty == '1);
    end
    check({name, "_drain"}, int'(done), 1);
  endtask

  function automatic int visit_beats(input int k);
    if (k + 1 < gl_start.size()) return gl_start[k+1] - gl_start[k];
    return pop_log.size() - gl_start[k];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_g, base_p, n;
    bit seen;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_grant_ch",  int'(grant_ch), NUM_CH - 1);
    check("rst_rd_en",     int'(ch_rd_en), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_out_ch",    int'(out_ch), 0);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;

    // Single channel, three words, latency and termination on empty
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      push(1, 'hA0 + i);
      expect_word(1, 'hA0 + i);
    end
    @(negedge clk); #2;
    check("single_busy_after_grant", int'(busy), 1);
    check("single_grant_ch",         int'(grant_ch), 1);
    check("single_no_valid_yet",     int'(out_valid), 0);
    check("single_rd_en",            int'(ch_rd_en), 'b0010);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      check("single_valid",   int'(out_valid), 1);
      check("single_data",    int'(out_data), 'hA0 + i);
      check("single_out_ch",  int'(out_ch), 1);
    end
    @(negedge clk); #2;
    check("single_idle_after_empty", int'(busy), 0);
    check("single_valid_drained",    int'(out_valid), 0);
    wait_idle("single");
    check("single_pops", rd_ptr[1], 3);

    // Round-robin over four channels with six words each
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    base_g = gl_ch.size();
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < 6; i++) push(c, 'h80 + c * 16 + i);
    for (int v = 0; v < 2; v++)
      for (int c = 0; c < NUM_CH; c++)
        for (int i = 0; i < (v == 0 ? 4 : 2); i++) expect_word(c, 'h80 + c * 16 + v * 4 + i);
    wait_idle("rr");
    check("rr_grant_count", gl_ch.size() - base_g, 8);
    n = (gl_ch.size() - base_g < 8) ? gl_ch.size() - base_g : 8;
    for (int k = 0; k < n; k++) begin
      check("rr_grant_order", gl_ch[base_g + k], k % NUM_CH);
      check("rr_visit_beats", visit_beats(base_g + k), (k < NUM_CH) ? 4 : 2);
    end

    // Backpressure on channel 2
    @(negedge clk);
    base_p = rd_ptr[2];
    for (int i = 0; i < 4; i++) begin
      push(2, 'hC0 + i);
      expect_word(2, 'hC0 + i);
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #2;
      seen = out_valid;
    end
    check("bp_first_valid", int'(seen), 1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #2;
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_data",  int'(out_data), 'hC0);
      check("bp_hold_ch",    int'(out_ch), 2);
      check("bp_no_rd_en",   int'(ch_rd_en), 0);
    end
    check("bp_one_pop", rd_ptr[2] - base_p, 1);
    out_ready = 1'b1;
    for (int j = 1; j < 4; j++) begin
      @(negedge clk); #2;
      check("bp_b2b_valid", int'(out_valid), 1);
      check("bp_b2b_data",  int'(out_data), 'hC0 + j);
    end
    wait_idle("bp");

    // Enable gating; grant pointer is 2, so ch3 is served before ch0
    @(negedge clk);
    enable = 1'b0;
    base_p = rd_ptr[0];
    for (int i = 0; i < 6; i++) push(0, 'hE0 + i);
    push(3, 'hF0);
    push(3, 'hF1);
    expect_word(3, 'hF0);
    expect_word(3, 'hF1);
    for (int i = 0; i < 4; i++) expect_word(0, 'hE0 + i);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #2;
      check("en_off_busy",  int'(busy), 0);
      check("en_off_rd_en", int'(ch_rd_en), 0);
    end
    enable = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #2;
      seen = busy && (grant_ch == 0) && out_valid && (out_ch == 0);
    end
    check("en_ch0_burst_started", int'(seen), 1);
    enable = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk); #2;
      seen = !busy;
    end
    check("en_burst_completed", int'(seen), 1);
    check("en_ch0_pops", rd_ptr[0] - base_p, BURST_MAX);
    check("en_last_visit_beats", visit_beats(gl_ch.size() - 1), BURST_MAX);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #2;
      check("en_stays_idle", int'(busy), 0);
      check("en_idle_rd_en", int'(ch_rd_en), 0);
    end
    check("en_words_delivered", mon_idx, exp_log.size());
    expect_word(0, 'hE4);
    expect_word(0, 'hE5);
    enable = 1'b1;
    wait_idle("en_resume");

    // Fairness wrap: ch3 keeps requesting after its burst, ch0 must go next
    @(negedge clk);
    enable = 1'b0;
    base_g = gl_ch.size();
    for (int i = 0; i < 5; i++) push(3, 'hD0 + i);
    push(0, 'hB0);
    push(0, 'hB1);
    for (int i = 0; i < 4; i++) expect_word(3, 'hD0 + i);
    expect_word(0, 'hB0);
    expect_word(0, 'hB1);
    expect_word(3, 'hD4);
    @(negedge clk);
    enable = 1'b1;
    wait_idle("wrap");
    check("wrap_grant_count", gl_ch.size() - base_g, 3);
    if (gl_ch.size() - base_g >= 3) begin
      check("wrap_first",  gl_ch[base_g],     3);
      check("wrap_second", gl_ch[base_g + 1], 0);
      check("wrap_third",  gl_ch[base_g + 2], 3);
    end

    // Asynchronous reset mid-burst; the word in the output register is lost
    @(negedge clk);
    base_p = rd_ptr[1];
    for (int i = 0; i < 4; i++) push(1, 'h51 + i);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk); #2;
      seen = out_valid;
    end
    check("arst_burst_started", int'(seen), 1);
    check("arst_busy_before",   int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_busy",      int'(busy), 0);
    check("arst_rd_en",     int'(ch_rd_en), 0);
    check("arst_grant_ch",  int'(grant_ch), NUM_CH - 1);
    push(0, 'h60);
    expect_word(0, 'h60);
    for (int i = 1; i < 4; i++) expect_word(1, 'h51 + i);
    base_g = gl_ch.size();
    @(negedge clk);
    rst_n = 1'b1;
    wait_idle("post_rst");
    check("post_rst_grant_count", int'(gl_ch.size() - base_g >= 2), 1);
    if (gl_ch.size() - base_g >= 2) begin
      check("post_rst_first_grant",  gl_ch[base_g],     0);
      check("post_rst_second_grant", gl_ch[base_g + 1], 1);
    end
    check("post_rst_ch1_pops", rd_ptr[1] - base_p, 4);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
